iomem_dma_initiator: RTL and testbench
======================================

// Module: iomem_dma_initiator
// PURPOSE
//  Bus initiator for the PicoRV32 native iomem protocol (valid/ready/addr/wdata/wstrb/rdata).
//  Copies cmd_len 32-bit words from a source to a destination address, one read then one write per word.
//  Sits alongside the CPU as a second iomem master, e.g. to drain the RNG data port (0x0300_1000) into RAM.
//  Source may be incrementing or fixed (peripheral FIFO/port); destination always increments.
// PARAMETERS
//  LEN_W    16    width of word count / progress counter
//  TIMEOUT  1024  cycles mem_valid may wait for mem_ready before abort (IOMEM_DMA_TIMEOUT_EN only)
// PORTS
//  clk          in   1      system clock; single clock domain
//  resetn       in   1      asynchronous, active-low reset
//  cmd_valid    in   1      start request; accepted when cmd_valid && cmd_ready
//  cmd_ready    out  1      high only in IDLE
//  cmd_src      in   32     source byte address; bits [1:0] ignored (forced 0)
//  cmd_dst      in   32     destination byte address; bits [1:0] ignored (forced 0)
//  cmd_len      in   LEN_W  number of words to copy; 0 legal
//  cmd_src_inc  in   1      1: src += 4 per word; 0: fixed source address
//  busy         out  1      high from accept until the done pulse's cycle
//  done         out  1      one-cycle pulse on completion or abort
//  err          out  1      sticky abort flag; cleared on next accepted command
//  words_done   out  LEN_W  words fully written in current/last command
//  mem_valid    out  1      iomem request
//  mem_ready    in   1      iomem completion, one cycle
//  mem_wstrb    out  4      4'b0000 read, 4'b1111 write
//  mem_addr     out  32     request address
//  mem_wdata    out  32     write data (holds last read word)
//  mem_rdata    in   32     read data, sampled when mem_valid && mem_ready
// BEHAVIOUR
//  Reset (async): state IDLE; mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0;
//   busy=0, done=0, err=0, words_done=0; cmd_ready=1 once reset deasserts.
//  FSM: IDLE -> RD_REQ -> RD_GAP -> WR_REQ -> WR_GAP -> (RD_REQ | FIN) ; FIN -> IDLE.
//  IDLE: on cmd accept latch src/dst/len/inc, clear words_done & err; len==0 -> FIN, else RD_REQ.
//  RD_REQ: mem_valid=1, wstrb=0, addr=src; addr/wstrb stable until mem_ready.
//   On handshake: mem_wdata<=mem_rdata, mem_valid<=0, -> RD_GAP.
//  RD_GAP/WR_GAP: mem_valid=0 exactly one cycle (responders guard on !ready; no back-to-back valid).
//  WR_REQ: mem_valid=1, wstrb=4'b1111, addr=dst, wdata stable. On handshake: words_done+1, dst+=4,
//   src+=4 if inc, -> WR_GAP. WR_GAP: words_done==len -> FIN else RD_REQ.
//  FIN: done=1 for one cycle, busy=0 in the same cycle, -> IDLE; cmd_ready=1 the following cycle.
//  Latency: accept at T -> read request visible at T+1; per word = 2 handshakes + 2 gap cycles.
//  Address arithmetic mod 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000, no error.
//  cmd_valid while busy: ignored, not queued. mem_ready while mem_valid=0: ignored.
//  Reset mid-transfer: mem_valid drops immediately (async); transfer lost, no done pulse.
// CONFIGURATION
//  IOMEM_DMA_TIMEOUT_EN defined: per-request counter starts at mem_valid rise, clears on handshake;
//   reaching TIMEOUT cycles -> mem_valid=0, err=1, -> FIN (done pulses), words_done keeps count.
//  Undefined: no counter; initiator waits indefinitely for mem_ready; err tied 0.
// STRUCTURE
//  Package iomem_dma_pkg: state encoding (IDLE,RD_REQ,RD_GAP,WR_REQ,WR_GAP,FIN),
//   WSTRB_RD=4'b0000, WSTRB_WR=4'b1111, WORD_BYTES=4.
//  Sub-module iomem_dma_timeout: load/clear/expire counter, instantiated only under the macro.
// TESTING
//  1 len=3 src=0x100 inc=1 dst=0x200, ready 1 cycle after valid -> reads 0x100,0x104,0x108,
//    writes 0x200..0x208 with matching data; done once; words_done=3; err=0.
//  2 len=4 src=0x0300_1000 inc=0, RNG-style responder -> all 4 reads at 0x0300_1000, dst increments.
//  3 len=0 -> no mem_valid ever; done pulses 2 cycles after accept; busy high 1 cycle.
//  4 random 0-5 cycle ready stalls -> addr/wstrb/wdata stable while valid; valid low >=1 cycle between requests.
//  5 dst=0xFFFF_FFF8 len=3 -> writes 0xFFFF_FFF8,0xFFFF_FFFC,0x0000_0000.
//  6 TIMEOUT_EN, TIMEOUT=8, responder never answers 2nd write -> valid drops after 8 cycles,
//    err=1, done pulse, words_done=1; next cmd clears err. Also: resetn low mid-read -> valid=0 at once.

Source files
------------

// File: rtl/iomem_dma_pkg.sv
// Shared types and constants for the iomem DMA initiator and its optional timeout counter.
package iomem_dma_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_GAP = 3'd2,
      WR_REQ = 3'd3,
      WR_GAP = 3'd4,
      FIN    = 3'd5
   } dma_state_e;

   localparam logic [3:0]  WSTRB_RD   = 4'b0000;
   localparam logic [3:0]  WSTRB_WR   = 4'b1111;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/iomem_dma_timeout.sv
// Per-request watchdog: counts cycles an iomem request waits for ready and flags expiry.
// Instantiated by iomem_dma_initiator only when IOMEM_DMA_TIMEOUT_EN is defined.
module iomem_dma_timeout
   import iomem_dma_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic active,
   input  logic clear,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !active) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Fires during the TIMEOUT-th waiting cycle so the request is dropped at its end.
   assign expire = active && !clear && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iomem_dma_initiator.sv
// PicoRV32 iomem DMA initiator: copies cmd_len words src->dst, one read then one write per word.
// Request timeout/abort is built only when IOMEM_DMA_TIMEOUT_EN is defined.
module iomem_dma_initiator
   import iomem_dma_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_src,
   input  logic [31:0]      cmd_dst,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_src_inc,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [3:0]       mem_wstrb,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata
);

   dma_state_e       state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] words_done_q, words_done_d;
   logic             inc_q, inc_d;
   logic             mem_valid_q, mem_valid_d;
   logic [3:0]       mem_wstrb_q, mem_wstrb_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             handshake;
   logic             timeout_hit;

   assign handshake = mem_valid_q && mem_ready;

`ifdef IOMEM_DMA_TIMEOUT_EN
   iomem_dma_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .resetn (resetn),
      .active (mem_valid_q),
      .clear  (mem_ready),
      .expire (timeout_hit)
   );
`else
   // No watchdog: the initiator waits forever, so this never fires and err stays 0.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      inc_d        = inc_q;
      words_done_d = words_done_q;
      mem_valid_d  = mem_valid_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               src_d        = word_align(cmd_src);
               dst_d        = word_align(cmd_dst);
               len_d        = cmd_len;
               inc_d        = cmd_src_inc;
               words_done_d = '0;
               err_d        = 1'b0;
               busy_d       = 1'b1;
               if (cmd_len == '0) begin
                  state_d = FIN;
               end else begin
                  state_d     = RD_REQ;
                  mem_valid_d = 1'b1;
                  mem_wstrb_d = WSTRB_RD;
                  mem_addr_d  = word_align(cmd_src);
               end
            end
         end
         RD_REQ: begin
            if (handshake) begin
               mem_wdata_d = mem_rdata;
               mem_valid_d = 1'b0;
               state_d     = RD_GAP;
            end else if (timeout_hit) begin
               mem_valid_d = 1'b0;
               err_d       = 1'b1;
               state_d     = FIN;
            end
         end
         RD_GAP: begin
            mem_valid_d = 1'b1;
            mem_wstrb_d = WSTRB_WR;
            mem_addr_d  = dst_q;
            state_d     = WR_REQ;
         end
         WR_REQ: begin
            if (handshake) begin
               words_done_d = words_done_q + LEN_W'(1);
               dst_d        = dst_q + WORD_BYTES;
               if (inc_q) begin
                  src_d = src_q + WORD_BYTES;
               end
               mem_valid_d = 1'b0;
               state_d     = WR_GAP;
            end else if (timeout_hit) begin
               mem_valid_d = 1'b0;
               err_d       = 1'b1;
               state_d     = FIN;
            end
         end
         WR_GAP: begin
            if (words_done_q == len_q) begin
               state_d = FIN;
            end else begin
               mem_valid_d = 1'b1;
               mem_wstrb_d = WSTRB_RD;
               mem_addr_d  = src_q;
               state_d     = RD_REQ;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            mem_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase

      // Held low through the done cycle so a new command lands one cycle later.
      cmd_ready_d = (state_d == IDLE) && !done_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         inc_q        <= 1'b0;
         words_done_q <= '0;
         mem_valid_q  <= 1'b0;
         mem_wstrb_q  <= WSTRB_RD;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         inc_q        <= inc_d;
         words_done_q <= words_done_d;
         mem_valid_q  <= mem_valid_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign words_done = words_done_q;
   assign mem_valid  = mem_valid_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_iomem_dma_initiator.sv
// Bench for iomem_dma_initiator: random iomem responder, transaction scoreboard, command checks.
// Define IOMEM_DMA_TIMEOUT_EN to also exercise the abort path with TIMEOUT=8.
module tb_iomem_dma_initiator;
   import iomem_dma_pkg::*;

   localparam int LEN_W = 16;
`ifdef IOMEM_DMA_TIMEOUT_EN
   localparam int TIMEOUT = 8;
`else
   localparam int TIMEOUT = 1024;
`endif

   logic             clk;
   logic             resetn;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_src;
   logic [31:0]      cmd_dst;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_src_inc;
   logic             busy;
   logic             done;
   logic             err;
   logic [LEN_W-1:0] words_done;
   logic             mem_valid;
   logic             mem_ready;
   logic [3:0]       mem_wstrb;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   iomem_dma_initiator #(
      .LEN_W   (LEN_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_src     (cmd_src),
      .cmd_dst     (cmd_dst),
      .cmd_len     (cmd_len),
      .cmd_src_inc (cmd_src_inc),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .words_done  (words_done),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_wstrb   (mem_wstrb),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          total = 0;
   int          bad   = 0;
   logic [67:0] exp_q[$];        // {wstrb, addr, wdata (0 for reads)}
   logic [31:0] rd_data_q[$];    // words the responder returns, in order

   int min_stall = 0, max_stall = 0;
   bit stray_en = 0, resp_off = 0, hanging = 0;
   int stall_left = -1, wr_seen = 0, hang_wr = 0;

   int done_cnt = 0, valid_cycles = 0, vrun = 0, last_abort_run = 0;

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the bus transactions a copy must produce, in order.
   task automatic push_model(input logic [31:0] src, input logic [31:0] dst, input int len,
                             input bit inc, input int hang);
      logic [31:0] s, d, data;
      s = src & 32'hFFFF_FFFC;
      d = dst & 32'hFFFF_FFFC;
      for (int i = 0; i < len; i++) begin
         data = $urandom;
         rd_data_q.push_back(data);
         exp_q.push_back({WSTRB_RD, s, 32'h0});
         if (hang == i + 1) break;
         exp_q.push_back({WSTRB_WR, d, data});
         if (inc) s = s + 32'd4;
         d = d + 32'd4;
      end
   endtask

   // ---------------- responder ----------------
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!resetn || resp_off) begin
            mem_ready  = 1'b0;
            stall_left = -1;
            hanging    = 1'b0;
         end else if (mem_ready) begin
            mem_ready  = 1'b0;
            stall_left = -1;
         end else if (mem_valid) begin
            if (stall_left < 0) begin
               stall_left = $urandom_range(min_stall, max_stall);
               if (mem_wstrb == WSTRB_WR) begin
                  wr_seen++;
                  if (wr_seen == hang_wr) hanging = 1'b1;
               end
            end
            if (!hanging) begin
               if (stall_left == 0) begin
                  mem_ready = 1'b1;
                  if (mem_wstrb == WSTRB_RD)
                     mem_rdata = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'hDEAD_BEEF;
               end else begin
                  stall_left--;
               end
            end
         end else begin
            stall_left = -1;
            hanging    = 1'b0;
            if (stray_en && $urandom_range(0, 3) == 0) mem_ready = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic [67:0] prev_req, e;
      bit prev_valid, prev_hs, hs;
      prev_valid = 0;
      prev_hs    = 0;
      prev_req   = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_valid = 0;
            prev_hs    = 0;
            vrun       = 0;
         end else begin
            hs = mem_valid && mem_ready;
            if (prev_hs)
               chk("gap", 68'(mem_valid), 68'd0);
            else if (mem_valid && prev_valid)
               chk("stable", {mem_wstrb, mem_addr, mem_wdata}, prev_req);
            if (hs) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL xfer: got unexpected %0h addr %0h expected none", mem_wstrb, mem_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk("xfer", {mem_wstrb, mem_addr, (mem_wstrb == WSTRB_WR) ? mem_wdata : 32'h0}, e);
               end
            end
            if (mem_valid) begin
               vrun++;
               valid_cycles++;
            end else begin
               if (prev_valid && !prev_hs) last_abort_run = vrun;
               vrun = 0;
            end
            if (done) done_cnt++;
            prev_valid = mem_valid;
            prev_hs    = hs;
            prev_req   = {mem_wstrb, mem_addr, mem_wdata};
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [31:0] src, input logic [31:0] dst, input int len,
                        input bit inc, input int hang);
      int n;
      push_model(src, dst, len, inc, hang);
      wr_seen = 0;
      hang_wr = hang;
      @(negedge clk);
      cmd_src     = src;
      cmd_dst     = dst;
      cmd_len     = LEN_W'(len);
      cmd_src_inc = inc;
      cmd_valid   = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 68'(cmd_ready), 68'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int exp_words, input bit exp_err, input int budget, output int cyc);
      bit seen, busy_bad;
      int d0;
      d0 = done_cnt;
      seen = 0;
      busy_bad = 0;
      cyc = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            cyc  = c;
            break;
         end
         if (!busy) busy_bad = 1;
      end
      chk("done_seen", 68'(seen), 68'd1);
      chk("busy_during", 68'(busy_bad), 68'd0);
      if (seen) begin
         chk("busy_at_done", 68'(busy), 68'd0);
         chk("words_done", 68'(words_done), 68'(exp_words));
         chk("err", 68'(err), 68'(exp_err));
         chk("ready_at_done", 68'(cmd_ready), 68'd0);
         chk("sb_empty", 68'(exp_q.size()), 68'd0);
         @(negedge clk);
         chk("done_width", 68'(done), 68'd0);
         chk("ready_after", 68'(cmd_ready), 68'd1);
         chk("done_count", 68'(done_cnt - d0), 68'd1);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc, len, vc0, n, dc0;
      bit found;
      logic [31:0] src, dst;
      resetn      = 1'b0;
      cmd_valid   = 1'b0;
      cmd_src     = '0;
      cmd_dst     = '0;
      cmd_len     = '0;
      cmd_src_inc = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_outputs", {34'(mem_valid), mem_wstrb, mem_addr[29:0]}, 68'd0);
      chk("rst_wdata", 68'(mem_wdata), 68'd0);
      chk("rst_status", {64'(words_done), busy, done, err, 1'b0}, 68'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 68'(cmd_ready), 68'd1);

      // incrementing copy, ready one cycle after valid
      min_stall = 1; max_stall = 1;
      issue(32'h100, 32'h200, 3, 1'b1, 0);
      @(negedge clk);
      chk("first_read", {63'(mem_valid), mem_wstrb, 1'b0}, {63'd1, WSTRB_RD, 1'b0});
      chk("first_addr", 68'(mem_addr), 68'h100);
      wait_done(3, 1'b0, 200, cyc);

      // fixed-source drain of the RNG port; cmd_valid while busy is ignored
      min_stall = 0; max_stall = 2;
      issue(32'h0300_1000, 32'h0000_4000, 4, 1'b0, 0);
      cmd_src = 32'hAAAA_0000; cmd_dst = 32'hBBBB_0000; cmd_len = 16'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         chk("ready_while_busy", 68'(cmd_ready), 68'd0);
      end
      cmd_valid = 1'b0;
      wait_done(4, 1'b0, 300, cyc);

      // zero-length command: no bus traffic, done two cycles after accept
      vc0 = valid_cycles;
      issue(32'h1234, 32'h5678, 0, 1'b1, 0);
      wait_done(0, 1'b0, 20, cyc);
      chk("len0_latency", 68'(cyc), 68'd1);
      chk("len0_no_valid", 68'(valid_cycles - vc0), 68'd0);

      // destination wraps through 0xFFFF_FFFC
      issue(32'h0000_0203, 32'hFFFF_FFF8, 3, 1'b1, 0);
      wait_done(3, 1'b0, 300, cyc);

      // random commands with random stalls and stray ready pulses
      min_stall = 0; max_stall = 5; stray_en = 1;
      for (int t = 0; t < 8; t++) begin
         src = $urandom;
         dst = $urandom;
         len = $urandom_range(0, 6);
         issue(src, dst, len, 1'($urandom_range(0, 1)), 0);
         wait_done(len, 1'b0, 40 + len * 40, cyc);
      end
      stray_en = 0;

`ifdef IOMEM_DMA_TIMEOUT_EN
      // second write never answered: abort after TIMEOUT cycles of valid
      min_stall = 0; max_stall = 2;
      issue(32'h100, 32'h800, 3, 1'b1, 2);
      wait_done(1, 1'b1, 300, cyc);
      chk("abort_run", 68'(last_abort_run), 68'(TIMEOUT));
      rd_data_q.delete();
      issue(32'h100, 32'h900, 1, 1'b1, 0);
      @(negedge clk);
      chk("err_cleared", 68'(err), 68'd0);
      wait_done(1, 1'b0, 100, cyc);
`endif

      // asynchronous reset while a read is outstanding
      min_stall = 2; max_stall = 2;
      dc0 = done_cnt;
      issue(32'h2000, 32'h3000, 5, 1'b1, 0);
      found = 0;
      n = 0;
      while (!found && n < 60) begin
         @(negedge clk);
         n++;
         if (mem_valid && !mem_ready && mem_wstrb == WSTRB_RD) found = 1;
      end
      chk("mid_read_found", 68'(found), 68'd1);
      resp_off = 1;
      #2;
      resetn = 1'b0;
      #1;
      chk("reset_drops_valid", 68'(mem_valid), 68'd0);
      chk("reset_drops_busy", 68'(busy), 68'd0);
      exp_q.delete();
      rd_data_q.delete();
      @(negedge clk);
      resetn   = 1'b1;
      resp_off = 0;
      @(negedge clk);
      chk("post_reset_ready", 68'(cmd_ready), 68'd1);
      chk("post_reset_words", 68'(words_done), 68'd0);
      chk("no_done_on_reset", 68'(done_cnt - dc0), 68'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
